// File: rtl/inner_loop_param.sv
// Digit-serial a*bi inner loop: LANES parallel radix-digit multipliers emit a redundant
// product (r0 = low halves, r1 = high halves). Optional INNER_LOOP_ZERO_SKIP_EN shortcuts bi==0.
module inner_loop_param #(
  parameter int Size    = 3072,
  parameter int radix   = 78,
  parameter int LANES   = 20,
  parameter int MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [radix-1:0]        bi,
  input  logic [Size+1:0]         a,
  output logic                    in_ready,
  output logic [Size+radix+1:0]   r0,
  output logic [Size+radix+1:0]   r1,
  output logic                    en_out,
  output logic                    busy
);

  localparam int AW     = Size + 2;
  localparam int RW     = Size + radix + 2;
  localparam int N      = (AW + radix - 1) / radix;
  localparam int PASSES = (N + LANES - 1) / LANES;
  localparam int XW     = N * radix;
  localparam int PW     = $clog2(PASSES) + 1;
  localparam int CW     = $clog2(PASSES + MUL_LAT) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state_r;
  logic [CW-1:0]       cnt_r;
  logic [AW-1:0]       a_r;
  logic [radix-1:0]    bi_r;
  logic                accept_s;
  logic                skip_s;
  logic                issue_s;
  logic [XW-1:0]       a_ext_s;
  logic [radix-1:0]    dig_s  [LANES];
  logic [2*radix-1:0]  prod_s [LANES];
  logic [MUL_LAT-1:0]  valid_r;
  logic [PW-1:0]       pass_r [MUL_LAT];
  logic [2*radix-1:0]  prod_r [MUL_LAT][LANES];
  logic [RW-1:0]       nxt_r0_s;
  logic [RW-1:0]       nxt_r1_s;

  function automatic int lane_idx(input int pass, input int k);
    return pass * LANES + k;
  endfunction

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);
  assign accept_s = en && (state_r == IDLE);
  assign a_ext_s  = XW'(a_r);

`ifdef INNER_LOOP_ZERO_SKIP_EN
  assign skip_s = (bi_r == {radix{1'b0}});
`else
  assign skip_s = 1'b0;
`endif

  assign issue_s = (state_r == RUN) && !skip_s;

  // Digit selection and lane multipliers for the pass being issued
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      dig_s[k]  = (lane_idx(int'(cnt_r), k) < N) ?
                  radix'(a_ext_s >> (radix * lane_idx(int'(cnt_r), k))) : {radix{1'b0}};
      prod_s[k] = (2*radix)'(dig_s[k]) * (2*radix)'(bi_r);
    end
  end

  // Multiplier pipeline: products plus their pass index travel MUL_LAT stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        pass_r[s] <= '0;
        for (int k = 0; k < LANES; k++) prod_r[s][k] <= '0;
      end
    end else begin
      valid_r[0] <= issue_s;
      pass_r[0]  <= PW'(cnt_r);
      for (int k = 0; k < LANES; k++) prod_r[0][k] <= prod_s[k];
      for (int s = 1; s < MUL_LAT; s++) begin
        valid_r[s] <= valid_r[s-1];
        pass_r[s]  <= pass_r[s-1];
        for (int k = 0; k < LANES; k++) prod_r[s][k] <= prod_r[s-1][k];
      end
    end
  end

  // Merge retiring lane products into the result; targets were cleared at accept so OR suffices
  always_comb begin
    nxt_r0_s = r0;
    nxt_r1_s = r1;
    for (int k = 0; k < LANES; k++) begin
      nxt_r0_s = nxt_r0_s |
        (((valid_r[MUL_LAT-1] && lane_idx(int'(pass_r[MUL_LAT-1]), k) < N) ?
          RW'(prod_r[MUL_LAT-1][k][radix-1:0]) : {RW{1'b0}})
         << (radix * lane_idx(int'(pass_r[MUL_LAT-1]), k)));
      nxt_r1_s = nxt_r1_s |
        (((valid_r[MUL_LAT-1] && lane_idx(int'(pass_r[MUL_LAT-1]), k) < N) ?
          RW'(prod_r[MUL_LAT-1][k][2*radix-1:radix]) : {RW{1'b0}})
         << (radix * (lane_idx(int'(pass_r[MUL_LAT-1]), k) + 1)));
    end
  end

  // Control FSM, operand capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      bi_r    <= '0;
      r0      <= '0;
      r1      <= '0;
      en_out  <= 1'b0;
    end else begin
      en_out <= 1'b0;
      r0     <= nxt_r0_s;
      r1     <= nxt_r1_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            bi_r    <= bi;
            r0      <= '0;
            r1      <= '0;
            cnt_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (skip_s) begin
            state_r <= DONE;
            en_out  <= 1'b1;
          end else if (cnt_r == CW'(PASSES - 1)) begin
            cnt_r   <= '0;
            state_r <= DRAIN;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_r == CW'(MUL_LAT - 1)) begin
            cnt_r   <= '0;
            state_r <= DONE;
            en_out  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_loop_param.sv
// Self-checking bench for inner_loop_param: default build plus a small-parameter instance,
// checked against plain big-integer multiplication of the operands.
module tb_inner_loop_param;

  localparam int SZ  = 3072, RX  = 78, AW  = SZ + 2,  RW  = SZ + RX + 2;
  localparam int SZ2 = 100,  RX2 = 16, AW2 = SZ2 + 2, RW2 = SZ2 + RX2 + 2;
`ifdef INNER_LOOP_ZERO_SKIP_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en, en2;
  logic [RX-1:0]  bi;
  logic [RX2-1:0] bi2;
  logic [AW-1:0]  a;
  logic [AW2-1:0] a2;
  logic in_ready, in_ready2, en_out, en_out2, busy, busy2;
  logic [RW-1:0]  r0, r1;
  logic [RW2-1:0] r0b, r1b;

  int total  = 0;
  int passed = 0;

  inner_loop_param dut (
    .clk(clk), .rst(rst), .en(en), .bi(bi), .a(a), .in_ready(in_ready),
    .r0(r0), .r1(r1), .en_out(en_out), .busy(busy)
  );

  inner_loop_param #(.Size(SZ2), .radix(RX2), .LANES(3), .MUL_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .bi(bi2), .a(a2), .in_ready(in_ready2),
    .r0(r0b), .r1(r1b), .en_out(en_out2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
  endtask

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] v = '0;
    for (int i = 0; i < AW / 32 + 1; i++) v = AW'({v, $urandom()});
    return v;
  endfunction

  function automatic logic [RX-1:0] rand_b();
    logic [RX-1:0] v = '0;
    for (int i = 0; i < 3; i++) v = RX'({v, $urandom()});
    return v | RX'(1);
  endfunction

  // Drive one start on dut and measure negedges from the accept edge to en_out
  task automatic run_op(input logic [AW-1:0] av, input logic [RX-1:0] bv, output int lat);
    @(negedge clk);
    a = av; bi = bv; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    lat = 1;
    while (!en_out && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op2(input logic [AW2-1:0] av, input logic [RX2-1:0] bv, output int lat);
    @(negedge clk);
    a2 = av; bi2 = bv; en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    lat = 1;
    while (!en_out2 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [AW-1:0]  av;
  logic [RX-1:0]  bv;
  logic [AW2-1:0] av2;
  logic [RX2-1:0] bv2;
  logic [RW-1:0]  bb_exp [24];
  int lat;
  int pulses;

  initial begin
    rst = 1'b0; en = 1'b0; en2 = 1'b0;
    a = '0; bi = '0; a2 = '0; bi2 = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_r0", r0, '0);
    chk("rst_r1", r1, '0);
    chk("rst_en_out", RW'(en_out), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_busy2", RW'(busy2), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", RW'(in_ready), RW'(1));
    chk("in_ready2_after_rst", RW'(in_ready2), RW'(1));

    // all-ones operands
    av = '1; bv = '1;
    run_op(av, bv, lat);
    chk("max_latency", RW'(lat), RW'(5));
    chk("max_sum", r0 + r1, RW'(av) * RW'(bv));
    chk("max_r1_low", RW'(r1[RX-1:0]), '0);

    // a=1, bi=5
    run_op(AW'(1), RX'(5), lat);
    chk("small_latency", RW'(lat), RW'(5));
    chk("small_r0", r0, RW'(5));
    chk("small_r1", r1, '0);
    @(negedge clk);
    chk("pulse_width", RW'(en_out), '0);
    chk("hold_r0", r0, RW'(5));
    chk("ready_after_done", RW'(in_ready), RW'(1));

    // asynchronous clear of held, nonzero result
    rst = 1'b1;
    #1;
    chk("async_clr_r0", r0, '0);
    chk("async_clr_busy", RW'(busy), '0);
    @(negedge clk);
    rst = 1'b0;

    // random operands
    for (int i = 0; i < 3; i++) begin
      av = rand_a(); bv = rand_b();
      run_op(av, bv, lat);
      chk("rand_latency", RW'(lat), RW'(5));
      chk("rand_sum", r0 + r1, RW'(av) * RW'(bv));
      chk("rand_r1_low", RW'(r1[RX-1:0]), '0);
    end

    // reset two cycles into an operation
    @(negedge clk);
    a = rand_a(); bi = rand_b(); en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_r0", r0, '0);
    chk("abort_r1", r1, '0);
    chk("abort_busy", RW'(busy), '0);
    chk("abort_en_out", RW'(en_out), '0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en_out) pulses++;
    end
    chk("abort_no_en_out", RW'(pulses), '0);
    av = rand_a(); bv = rand_b();
    run_op(av, bv, lat);
    chk("post_abort_latency", RW'(lat), RW'(5));
    chk("post_abort_sum", r0 + r1, RW'(av) * RW'(bv));

    // bi == 0
    run_op(rand_a(), '0, lat);
    chk("zero_latency", RW'(lat), RW'(ZLAT));
    chk("zero_r0", r0, '0);
    chk("zero_r1", r1, '0);

    // en held high with fresh operands every cycle: accepts every 6 cycles
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      av = rand_a(); bv = rand_b();
      a = av; bi = bv; en = 1'b1;
      bb_exp[c] = RW'(av) * RW'(bv);
      @(negedge clk);
      chk("b2b_en_out", RW'(en_out), RW'((c % 6) == 4));
      if ((c % 6) == 4) chk("b2b_sum", r0 + r1, bb_exp[c-4]);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);

    // small configuration: N=7, PASSES=3, MUL_LAT=1
    for (int i = 0; i < 4; i++) begin
      av2 = AW2'({$urandom(), $urandom(), $urandom(), $urandom()});
      bv2 = RX2'($urandom()) | RX2'(1);
      run_op2(av2, bv2, lat);
      chk("p2_latency", RW'(lat), RW'(5));
      chk("p2_sum", RW'(RW2'(r0b + r1b)), RW'(RW2'(RW2'(av2) * RW2'(bv2))));
      chk("p2_r1_low", RW'(r1b[RX2-1:0]), '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inner_loop_param.md
INNER_LOOP_PARAM -- requirements
Module: inner_loop_param

Interface
REQ-001 Parameter Size, default 3072: operand a is Size+2 bits wide.
REQ-002 Parameter radix, default 78: digit width of bi and of each partial product half.
REQ-003 Parameter LANES, default 20: number of digit multipliers working in parallel.
REQ-004 Parameter MUL_LAT, default 2, range 1..4: multiplier pipeline depth in cycles.
REQ-005 Derived values: N = ceil((Size+2)/radix) digits and PASSES = ceil(N/LANES); for the defaults, N=40 and PASSES=2.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port en, input, 1 bit: start request, valid together with a and bi.
REQ-009 Port bi, input, radix bits: multiplier digit.
REQ-010 Port a, input, Size+2 bits: multiplicand.
REQ-011 Port in_ready, output, 1 bit: high only in IDLE; a start is accepted on a clock edge where en && in_ready.
REQ-012 Port r0, output, Size+radix+2 bits: low-half digits of the redundant product.
REQ-013 Port r1, output, Size+radix+2 bits: high-half digits of the redundant product.
REQ-014 Port en_out, output, 1 bit: one-cycle pulse marking r0/r1 as complete.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 On accept, a and bi SHALL be captured; a SHALL be zero-extended to N*radix bits and split into digits a_j = a[radix*j +: radix].
REQ-017 The state machine SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on accept.
- RUN issues pass p (p = 0..PASSES-1) in its p-th cycle; lane k multiplies digit a_(p*LANES+k) by bi, and lanes with an index at or beyond N are fed zero.
- RUN -> DRAIN after the last pass; DRAIN lasts MUL_LAT cycles.
- DRAIN -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-018 Each lane product (2*radix bits) SHALL be written MUL_LAT cycles after its issue.
- The low half goes to r0[radix*j +: radix].
- The high half goes to r1[radix*(j+1) +: radix].
- Bits beyond the port width are discarded; they are always zero because a*bi < 2^(Size+radix+2).
REQ-019 r1[radix-1:0] SHALL always be zero.
REQ-020 At en_out, r0 + r1 SHALL equal a*bi exactly (mod 2^(Size+radix+2)).
REQ-021 en_out SHALL be high for exactly the DONE cycle; latency from the accept edge to the en_out rising edge is PASSES+MUL_LAT+1 cycles (5 for the defaults).
REQ-022 r0 and r1 SHALL be clocked registers only, with no latches.
REQ-023 r0 and r1 SHALL be cleared to zero on the accept edge and SHALL hold their final values from DONE until the next accept.
REQ-024 en while busy SHALL be ignored: no capture and no disturbance of the operation in flight.
- en in the DONE cycle is also ignored.
- en in the IDLE cycle that follows DONE is accepted.
REQ-025 Back-to-back throughput SHALL be one result per PASSES+MUL_LAT+2 cycles.

Reset
REQ-026 rst high SHALL immediately, without waiting for a clock edge, force state to IDLE and set r0=0, r1=0, en_out=0 and busy=0.
REQ-027 rst high SHALL also clear the captured operands and the multiplier pipelines.
REQ-028 A reset during any state SHALL abort the operation; no en_out is produced for it.
REQ-029 in_ready SHALL be high on the first edge after rst is released.

Configuration
REQ-030 Macro INNER_LOOP_ZERO_SKIP_EN defined: an accept with bi==0 SHALL go directly to DONE, so en_out rises 2 cycles after the accept edge with r0=r1=0.
REQ-031 Macro INNER_LOOP_ZERO_SKIP_EN not defined: bi==0 SHALL follow the normal path with the full latency and zero results.

Verification
REQ-032 Defaults, a = 2^3074-1, bi = 2^78-1, en pulsed once -> en_out exactly 5 cycles after the accept edge; r0+r1 == a*bi; r1[77:0]==0.
REQ-033 Defaults, a=1, bi=5 -> r0[77:0]=5; all other r0 bits 0; r1=0.
REQ-034 Defaults, en held high continuously with a new random a and bi each cycle -> one result every 6 cycles; each result matches the operands captured at its accept.
REQ-035 Defaults, rst pulsed 2 cycles after an accept -> r0=r1=0 immediately; no en_out; the next accept completes correctly.
REQ-036 Size=100, radix=16, LANES=3, MUL_LAT=1 (N=7, PASSES=3) with random operands -> latency 5 cycles; r0+r1 == a*bi.
REQ-037 bi=0, a random -> with INNER_LOOP_ZERO_SKIP_EN, en_out at 2 cycles; without it, en_out at 5 cycles; in both cases r0=r1=0.
